// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo: serial loopback. Frames received on io_rx are buffered in a
// small FIFO and sent back out on io_tx without change.
// Ports:
//   clock          system clock, rising edge
//   reset          asynchronous active-low reset
//   io_rx          serial input (idles high, asynchronous to clock)
//   io_tx          serial echo output (idles high)
//   io_cts         clear-to-send, sampled only between transmitted frames
//   io_frame_err   sticky: a received stop bit sampled 0
//   io_parity_err  sticky: received parity did not match
//   io_overflow    sticky: a good byte arrived while the FIFO was full
//   io_count       current FIFO occupancy
module uart_echo_fifo #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned DEPTH        = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       io_rx,
    output logic                       io_tx,
    input  logic                       io_cts,
    output logic                       io_frame_err,
    output logic                       io_parity_err,
    output logic                       io_overflow,
    output logic [$clog2(DEPTH+1)-1:0] io_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned BW = $clog2(STOP_BITS * CLKS_PER_BIT + 1);
    localparam int unsigned IW = $clog2(DATA_BITS + 1);

    localparam logic [BW-1:0] HALF_BIT  = BW'(CLKS_PER_BIT / 2);
    localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
    // The IDLE cycle before the next start bit supplies the last stop cycle.
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS * CLKS_PER_BIT - 2);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
    localparam logic          PAR_ODD   = 1'(PARITY == 1);

    typedef enum logic [2:0] {
        RX_WAIT_IDLE,
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    logic rx_meta;
    logic rx_sync;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= io_rx;
            rx_sync <= rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    rx_state_t            rx_state;
    logic [BW-1:0]        rx_baud;
    logic [IW-1:0]        rx_idx;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_pbit;
    logic                 rx_tick_c;
    logic                 par_bad_c;
    logic                 push_c;

    assign rx_tick_c = (rx_baud == '0);
    assign par_bad_c = (PARITY != 0) && (((^rx_shift) ^ rx_pbit) != PAR_ODD);
    // A good byte is written on the edge that ends the stop-sample cycle.
    assign push_c    = (rx_state == RX_STOP) && rx_tick_c && rx_sync && !par_bad_c;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_state      <= RX_WAIT_IDLE;
            rx_baud       <= '0;
            rx_idx        <= '0;
            rx_shift      <= '0;
            rx_pbit       <= 1'b0;
            io_frame_err  <= 1'b0;
            io_parity_err <= 1'b0;
        end else begin
            case (rx_state)
                // Skip any frame already on the line when reset released.
                RX_WAIT_IDLE: begin
                    if (rx_sync) rx_state <= RX_IDLE;
                end
                RX_IDLE: begin
                    if (!rx_sync) begin
                        rx_state <= RX_START;
                        rx_baud  <= HALF_BIT;
                    end
                end
                RX_START: begin
                    if (rx_tick_c) begin
                        if (rx_sync) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_state <= RX_DATA;
                            rx_baud  <= BIT_LAST;
                            rx_idx   <= '0;
                        end
                    end else begin
                        rx_baud <= rx_baud - BW'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_tick_c) begin
                        rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
                        rx_baud  <= BIT_LAST;
                        if (rx_idx == IDX_LAST) begin
                            rx_state <= (PARITY != 0) ? RX_PARITY : RX_STOP;
                        end else begin
                            rx_idx <= rx_idx + IW'(1);
                        end
                    end else begin
                        rx_baud <= rx_baud - BW'(1);
                    end
                end
                RX_PARITY: begin
                    if (rx_tick_c) begin
                        rx_pbit  <= rx_sync;
                        rx_baud  <= BIT_LAST;
                        rx_state <= RX_STOP;
                    end else begin
                        rx_baud <= rx_baud - BW'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_tick_c) begin
                        if (par_bad_c) io_parity_err <= 1'b1;
                        if (!rx_sync) begin
                            io_frame_err <= 1'b1;
                            rx_state     <= RX_WAIT_IDLE;
                        end else begin
                            rx_state <= RX_IDLE;
                        end
                    end else begin
                        rx_baud <= rx_baud - BW'(1);
                    end
                end
                default: rx_state <= RX_WAIT_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO: pointers carry one wrap bit so full and empty are distinct
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic                 empty_c;
    logic                 full_c;
    logic                 pop_c;
    logic                 wr_en_c;
    tx_state_t            tx_state;

    assign empty_c = (wr_ptr == rd_ptr);
    assign full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_c   = (tx_state == TX_IDLE) && !empty_c && io_cts;
    // A simultaneous pop frees the slot, so a push into a full FIFO is kept.
    assign wr_en_c = push_c && (!full_c || pop_c);

    always_ff @(posedge clock) begin
        if (wr_en_c) mem[wr_ptr[AW-1:0]] <= rx_shift;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            io_count    <= '0;
            io_overflow <= 1'b0;
        end else begin
            if (wr_en_c) wr_ptr <= wr_ptr + PW'(1);
            if (pop_c) rd_ptr <= rd_ptr + PW'(1);
            if (push_c && !wr_en_c) io_overflow <= 1'b1;
            case ({wr_en_c, pop_c})
                2'b10:   io_count <= io_count + CW'(1);
                2'b01:   io_count <= io_count - CW'(1);
                default: io_count <= io_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    logic [BW-1:0]        tx_baud;
    logic [IW-1:0]        tx_idx;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_pbit;
    logic                 tx_tick_c;

    assign tx_tick_c = (tx_baud == '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_state <= TX_IDLE;
            tx_baud  <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            tx_pbit  <= 1'b0;
            io_tx    <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    io_tx <= 1'b1;
                    if (pop_c) begin
                        tx_state <= TX_START;
                        io_tx    <= 1'b0;
                        tx_shift <= mem[rd_ptr[AW-1:0]];
                        tx_pbit  <= (^mem[rd_ptr[AW-1:0]]) ^ PAR_ODD;
                        tx_baud  <= BIT_LAST;
                    end
                end
                TX_START: begin
                    if (tx_tick_c) begin
                        tx_state <= TX_DATA;
                        io_tx    <= tx_shift[0];
                        tx_idx   <= '0;
                        tx_baud  <= BIT_LAST;
                    end else begin
                        tx_baud <= tx_baud - BW'(1);
                    end
                end
                TX_DATA: begin
                    if (tx_tick_c) begin
                        if (tx_idx == IDX_LAST) begin
                            if (PARITY != 0) begin
                                tx_state <= TX_PARITY;
                                io_tx    <= tx_pbit;
                                tx_baud  <= BIT_LAST;
                            end else begin
                                tx_state <= TX_STOP;
                                io_tx    <= 1'b1;
                                tx_baud  <= STOP_LAST;
                            end
                        end else begin
                            tx_idx   <= tx_idx + IW'(1);
                            tx_shift <= tx_shift >> 1;
                            io_tx    <= tx_shift[1];
                            tx_baud  <= BIT_LAST;
                        end
                    end else begin
                        tx_baud <= tx_baud - BW'(1);
                    end
                end
                TX_PARITY: begin
                    if (tx_tick_c) begin
                        tx_state <= TX_STOP;
                        io_tx    <= 1'b1;
                        tx_baud  <= STOP_LAST;
                    end else begin
                        tx_baud <= tx_baud - BW'(1);
                    end
                end
                TX_STOP: begin
                    io_tx <= 1'b1;
                    if (tx_tick_c) begin
                        tx_state <= TX_IDLE;
                    end else begin
                        tx_baud <= tx_baud - BW'(1);
                    end
                end
                default: begin
                    tx_state <= TX_IDLE;
                    io_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_echo_fifo.sv
// tb_uart_echo_fifo: directed bench for uart_echo_fifo. Instance u0 uses the
// default frame format (8N1, depth 4); u1 uses 7 data bits, even parity and
// two stop bits. Both run at 8 clocks per bit.
`timescale 1ns/1ps
module tb_uart_echo_fifo;

    localparam int unsigned C = 8;
    // Line start-bit edge to echo start bit: 2 sync + 1 idle detect + C/2
    // + C per remaining bit up to the stop sample (9 bits) + 2 => 81.
    localparam int LAT = 81;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst0, rx0, tx0, cts0, fe0, pe0, ov0;
    logic [2:0] cnt0;
    logic       rst1, rx1, tx1, cts1, fe1, pe1, ov1;
    logic [2:0] cnt1;

    uart_echo_fifo #(
        .CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DEPTH(4)
    ) u0 (
        .clock(clk), .reset(rst0), .io_rx(rx0), .io_tx(tx0), .io_cts(cts0),
        .io_frame_err(fe0), .io_parity_err(pe0), .io_overflow(ov0), .io_count(cnt0)
    );

    uart_echo_fifo #(
        .CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .DEPTH(4)
    ) u1 (
        .clock(clk), .reset(rst1), .io_rx(rx1), .io_tx(tx1), .io_cts(cts1),
        .io_frame_err(fe1), .io_parity_err(pe1), .io_overflow(ov1), .io_count(cnt1)
    );

    int total = 0;
    int bad   = 0;
    int k0    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one 10-bit line frame: start, data, parity (u1 only), one stop bit.
    task automatic send_frame(input int sel, input logic [7:0] d, input logic pb,
                              input logic stp);
        logic [9:0] bits;
        if (sel == 0) bits = {stp, d, 1'b0};
        else          bits = {stp, pb, d[6:0], 1'b0};
        k0 = cyc;
        for (int i = 0; i < 10; i++) begin
            if (sel == 0) rx0 = bits[0];
            else          rx1 = bits[0];
            bits = bits >> 1;
            repeat (C) @(posedge clk);
            #1;
        end
        if (sel == 0) rx0 = 1'b1;
        else          rx1 = 1'b1;
    endtask

    // Capture one echoed frame; every cycle of a bit must hold its value.
    task automatic recv_frame(input int sel, output logic [7:0] d, output logic pb,
                              output logic stop_ok, output logic glitch,
                              output int t_fall, output logic tmo);
        logic [10:0] bits;
        logic        v, first;
        int          nb;
        nb      = (sel == 0) ? 10 : 11;
        tmo     = 1'b1;
        t_fall  = 0;
        d       = '0;
        pb      = 1'b0;
        stop_ok = 1'b0;
        glitch  = 1'b0;
        bits    = '0;
        first   = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            v = (sel == 0) ? tx0 : tx1;
            if (v === 1'b0) begin
                tmo    = 1'b0;
                t_fall = cyc;
                break;
            end
        end
        if (!tmo) begin
            for (int k = 0; k < nb; k++) begin
                for (int j = 0; j < int'(C); j++) begin
                    if (k != 0 || j != 0) @(negedge clk);
                    v = (sel == 0) ? tx0 : tx1;
                    if (j == 0) first = v;
                    else if (v !== first) glitch = 1'b1;
                    if (j == int'(C / 2)) bits = {v, bits[10:1]};
                end
            end
            if (sel == 0) begin
                d       = bits[9:2];
                stop_ok = bits[10] & ~bits[1];
            end else begin
                d       = {1'b0, bits[7:1]};
                pb      = bits[8];
                stop_ok = bits[9] & bits[10] & ~bits[0];
            end
        end
    endtask

    task automatic expect_frame(input int sel, input logic [7:0] ed, input logic ep,
                                input string tag, output int tf);
        logic [7:0] d;
        logic       pb, sok, gl, tmo;
        recv_frame(sel, d, pb, sok, gl, tf, tmo);
        chk({tag, "_seen"}, 32'(tmo), 0);
        if (!tmo) begin
            chk({tag, "_data"}, 32'(d), 32'(ed));
            chk({tag, "_start_stop"}, 32'(sok), 1);
            chk({tag, "_bit_stable"}, 32'(gl), 0);
            if (sel == 1) chk({tag, "_parity"}, 32'(pb), 32'(ep));
        end
    endtask

    task automatic expect_quiet(input int sel, input int n, input string tag);
        logic saw, v;
        saw = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            v = (sel == 0) ? tx0 : tx1;
            if (v !== 1'b1) saw = 1'b1;
        end
        chk(tag, 32'(saw), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ka, tf, tfa, tfb, tu, k1;
        int tfs[4];

        rx0 = 1'b1; rx1 = 1'b1; cts0 = 1'b1; cts1 = 1'b1;
        rst0 = 1'b0; rst1 = 1'b0;
        idle(3);
        chk("rst_tx", 32'(tx0), 1);
        chk("rst_count", 32'(cnt0), 0);
        chk("rst_flags", 32'({fe0, pe0, ov0}), 0);
        chk("rst_tx_u1", 32'(tx1), 1);
        rst0 = 1'b1; rst1 = 1'b1;
        idle(2);

        // Basic echo, 8N1
        ka = 0; tfa = 0;
        fork
            begin
                send_frame(0, 8'h55, 1'b0, 1'b1);
                ka = k0;
                idle(4 * C);
                send_frame(0, 8'h4B, 1'b0, 1'b1);
            end
            begin
                expect_frame(0, 8'h55, 1'b0, "t1_a", tf);
                tfa = tf;
                expect_frame(0, 8'h4B, 1'b0, "t1_b", tf);
            end
        join
        chk("t1_latency", 32'(tfa - ka), 32'(LAT));
        chk("t1_flags", 32'({fe0, pe0, ov0}), 0);
        chk("t1_count", 32'(cnt0), 0);

        // Even parity, 7 data bits: good parity echoed, bad parity dropped
        idle(2 * C);
        fork
            send_frame(1, 8'h41, 1'b0, 1'b1);
            expect_frame(1, 8'h41, 1'b0, "t2_good", tf);
        join
        chk("t2_latency", 32'(tf - k0), 32'(LAT));
        idle(2 * C);
        fork
            send_frame(1, 8'h41, 1'b1, 1'b1);
            expect_quiet(1, 20 * C, "t2_dropped");
        join
        chk("t2_parity_err", 32'(pe1), 1);
        chk("t2_frame_err", 32'(fe1), 0);
        chk("t2_count", 32'(cnt1), 0);

        // Framing error, then recovery
        idle(2 * C);
        fork
            send_frame(0, 8'hA5, 1'b0, 1'b0);
            expect_quiet(0, 20 * C, "t3_dropped");
        join
        chk("t3_frame_err", 32'(fe0), 1);
        chk("t3_parity_err", 32'(pe0), 0);
        idle(2 * C);
        fork
            send_frame(0, 8'h3C, 1'b0, 1'b1);
            expect_frame(0, 8'h3C, 1'b0, "t3_next", tf);
        join
        chk("t3_count", 32'(cnt0), 0);

        // Flow control and overflow
        idle(2 * C);
        cts0 = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send_frame(0, 8'(i), 1'b0, 1'b1);
            idle(C);
        end
        chk("t4_count_full", 32'(cnt0), 4);
        chk("t4_overflow", 32'(ov0), 1);
        chk("t4_tx_held", 32'(tx0), 1);
        cts0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_frame(0, 8'(i + 1), 1'b0, "t4_echo", tf);
            tfs[i] = tf;
        end
        for (int i = 1; i < 4; i++) chk("t4_back_to_back", 32'(tfs[i] - tfs[i-1]), 10 * C);
        idle(2);
        chk("t4_count_empty", 32'(cnt0), 0);

        // Two stop bits; CTS drop mid-frame holds only the next frame
        idle(2 * C);
        cts1 = 1'b0;
        send_frame(1, 8'h12, 1'b0, 1'b1); idle(C);
        send_frame(1, 8'h34, 1'b1, 1'b1); idle(C);
        send_frame(1, 8'h56, 1'b0, 1'b1); idle(C);
        chk("t5_count", 32'(cnt1), 3);
        fork
            begin
                cts1 = 1'b1;
                repeat (3 * C) @(posedge clk);
                #1;
                cts1 = 1'b0;
            end
            expect_frame(1, 8'h12, 1'b0, "t5_a", tf);
        join
        chk("t5_count_held", 32'(cnt1), 2);
        expect_quiet(1, 6 * C, "t5_hold");
        idle(1);
        tu = cyc;
        cts1 = 1'b1;
        expect_frame(1, 8'h34, 1'b1, "t5_b", tfa);
        expect_frame(1, 8'h56, 1'b0, "t5_c", tfb);
        chk("t5_resume", 32'(tfa - tu), 1);
        chk("t5_two_stop_gap", 32'(tfb - tfa), 11 * C);

        // Reset while TX is in data bit 3 and RX in data bit 5
        idle(2 * C);
        cts0 = 1'b0;
        send_frame(0, 8'hF0, 1'b0, 1'b1);
        idle(C);
        chk("t6_queued", 32'(cnt0), 1);
        k1 = cyc;
        fork
            send_frame(0, 8'hD2, 1'b0, 1'b1);
            begin
                repeat (14) @(posedge clk);
                #1;
                cts0 = 1'b1;
                repeat (38) @(posedge clk);
                #1;
                chk("t6_tx_before", 32'(tx0), 0);
                #2;
                rst0 = 1'b0;
                #1;
                chk("t6_tx_async", 32'(tx0), 1);
                chk("t6_count", 32'(cnt0), 0);
                chk("t6_flags", 32'({fe0, pe0, ov0}), 0);
                repeat (6) @(posedge clk);
                #1;
                rst0 = 1'b1;
            end
        join
        chk("t6_release_cycle", 32'(cyc - k1), 80);
        idle(4 * C);
        fork
            send_frame(0, 8'h55, 1'b0, 1'b1);
            expect_frame(0, 8'h55, 1'b0, "t6_after", tf);
        join
        chk("t6_latency", 32'(tf - k0), 32'(LAT));
        chk("t6_count_end", 32'(cnt0), 0);
        chk("t6_flags_end", 32'({fe0, pe0, ov0}), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_echo_fifo.md
Name: uart_echo_fifo

Overview:
Parametrised UART echo. It receives serial frames on io_rx, buffers valid bytes in an internal FIFO, and retransmits them unchanged on io_tx. Data width, parity mode, stop-bit count, bit timing and buffer depth are configurable. A CTS flow-control input, error/overflow flags and a FIFO occupancy output are provided. It sits directly behind the board serial pins and is the standard loopback block for link bring-up and simulation.

Parameters:
CLKS_PER_BIT, 104, clock cycles per serial bit (104 = 115200 baud at 12 MHz); legal values are >= 4.
DATA_BITS, 8, data bits per frame, 5..8, sent and received LSB first.
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, number of stop bits the transmitter emits, 1 or 2.
DEPTH, 4, FIFO depth in bytes; must be a power of 2, >= 2.

Ports:
clock  input  1  system clock; all logic on the rising edge.
reset  input  1  asynchronous, active-low reset.
io_rx  input  1  serial input; idles high; asynchronous to clock.
io_tx  output 1  serial echo output; idles high.
io_cts  input  1  clear-to-send; 1 lets the transmitter start a new frame.
io_frame_err  output 1  sticky; set when a received stop bit samples 0.
io_parity_err  output 1  sticky; set on a parity mismatch.
io_overflow  output 1  sticky; set when a valid byte arrives while the FIFO is full.
io_count  output $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (reset=0, asynchronous):
  - io_tx=1; all flags 0; io_count=0; FIFO emptied.
  - RX and TX FSMs go to IDLE; bit counters and baud counters are zeroed.
  - Reset asserted mid-frame aborts the frame; io_tx goes to 1 immediately, without waiting for a clock.
- io_rx passes through a 2-FF synchroniser (reset value 1). Synchroniser latency is 2 cycles and is excluded from the timing below.
- RX FSM, states WAIT_IDLE -> IDLE -> START -> DATA -> PARITY -> STOP:
  - WAIT_IDLE (entered after reset): stay until the synchronised rx is seen at 1, so a frame already in progress at reset release is not decoded.
  - IDLE: synchronised rx=0 -> START, baud counter loaded with CLKS_PER_BIT/2 (integer division).
  - START: at the half-bit point, rx=1 is a false start -> IDLE with no flag; rx=0 -> DATA.
  - DATA: sample every CLKS_PER_BIT cycles, DATA_BITS samples, shifted in LSB first.
  - PARITY: entered only if PARITY!=0; one sample. Odd parity means the data bits plus the parity bit contain an odd number of 1s.
  - STOP: one sample. Only the first stop bit is checked, so incoming frames may have any stop length.
- Frame disposition, decided at the STOP sample (call it cycle S):
  - Stop sample = 0: set io_frame_err, discard the byte, wait in WAIT_IDLE until rx is high.
  - Parity mismatch (stop OK): set io_parity_err, discard the byte.
  - Both errors: set both flags.
  - Otherwise the byte is pushed into the FIFO at the clock edge ending cycle S. io_count increments at S+1. RX returns to IDLE at S+1, ready for a start bit in the same half-bit.
- FIFO:
  - Synchronous, registered read/write pointers with one extra wrap bit; full/empty derived from the pointers.
  - Push while full: byte dropped, io_overflow set, contents unchanged.
  - Push and pop in the same cycle: both happen and io_count is unchanged. This holds when full (the push is accepted, no overflow).
  - Pop while empty never occurs: TX pops only when count>0.
- TX FSM, states IDLE -> START -> DATA -> PARITY -> STOP:
  - IDLE: when FIFO non-empty and io_cts=1, pop the head byte; io_tx=0 is registered on the next edge.
  - Each bit lasts exactly CLKS_PER_BIT cycles. PARITY is skipped when PARITY=0. STOP lasts STOP_BITS*CLKS_PER_BIT cycles with io_tx=1.
  - After STOP, return to IDLE. A new frame can start the following cycle, so back-to-back frames have no gap beyond the stop bits.
  - io_cts is examined only in IDLE; deasserting it mid-frame never truncates a frame.
- Echo latency: with FIFO empty, TX idle and CTS=1, io_tx falls at cycle S+2. Push is at S, TX sees non-empty and pops at S+1, and the start bit is registered at S+2.
- Flags are sticky and cleared only by reset. Bytes leave in arrival order.

Test Plan:
- Defaults, CTS=1: send 0x55 then 'K' (0x4B), 4 bit-times apart -> io_tx reproduces each frame bit-exact (start, 8 data LSB first, 1 stop); the first echo start bit falls 2 cycles after the RX stop sample; all flags stay 0.
- PARITY=2, DATA_BITS=7: send 0x41 with parity bit 0, then 0x41 with parity bit 1 -> first frame echoed with parity 0; second frame dropped and io_parity_err=1; io_count returns to 0.
- Framing: send 0xA5 with stop bit driven 0 for one bit-time -> io_frame_err=1, nothing echoed; a following 0x3C sent after the line idles is echoed correctly.
- Flow control/overflow, DEPTH=4: CTS=0, send 0x01..0x05 -> io_count=4, io_overflow=1 after the 5th byte; raise CTS -> 0x01..0x04 echoed back-to-back in order, io_count reaches 0.
- STOP_BITS=2, CTS toggled low mid-frame -> the current frame completes with 2 stop bit-times; the next frame starts only after CTS returns to 1.
- Reset mid-operation: assert reset during TX data bit 3 and RX data bit 5 -> io_tx=1 immediately, io_count=0, flags 0; after release, the remainder of the in-flight RX frame is ignored (WAIT_IDLE), and the next full frame 0x55 is echoed correctly.
